pio_osr_unit: RTL and testbench
===============================

Name: pio_osr_unit

Overview:
- Read side of the 32-bit TX FIFO path: owns the output shift register (OSR) of a PIO state machine.
- Pulls words from the TX FIFO, either on an explicit PULL or automatically when a threshold is reached (autopull).
- Shifts 1..32 bits out per OUT instruction.
- Sits between the TX FIFO and the instruction execution unit; raises stall when the FIFO cannot supply data.

Parameters:
- DATA_W, 32: OSR and FIFO word width. Only 32 is supported.
- CNT_W, 6: width of the shift counter (range 0..32).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fifo_empty  in  1  TX FIFO empty flag, from the FIFO wrapper level tracker
- fifo_push  in  1  TX FIFO write strobe, same cycle as the FIFO sees it
- fifo_pull  out  1  TX FIFO read strobe, one-cycle pulse
- fifo_data  in  32  FIFO dout; valid the cycle after an honoured pull
- auto_pull  in  1  autopull enable
- pull_thresh  in  5  autopull threshold in bits; 0 means 32
- shift_right  in  1  1: shift right, LSBs out first; 0: shift left, MSBs out first
- out_req  in  1  OUT instruction active; held until done
- out_count  in  5  bits to shift out; 0 means 32
- pull_req  in  1  PULL instruction active; held until done
- pull_block  in  1  PULL blocks when the FIFO is empty
- scratch_x  in  32  X register; loaded into the OSR by a non-blocking PULL on empty FIFO
- out_data  out  32  shifted-out bits, right-aligned, zero-filled
- done  out  1  instruction completed this cycle
- stall  out  1  instruction pending and not completing
- osr  out  32  OSR contents
- shift_count  out  6  bits consumed from the OSR, 0..32

Behaviour:
- Reset values: osr=0, shift_count=32 (OSR empty), out_data=0, done=0, stall=0, fifo_pull=0, state=IDLE.
- Reset mid-fetch abandons the fetch. The FIFO read pointer may already have advanced; that word is lost, and this is accepted.
- States:
  - IDLE: accepts requests.
  - FETCH: fifo_pull issued; waits for fifo_data.
  - LOAD: loads the OSR.
- Pull eligibility: fifo_empty=0 and no refill already in flight.
- Honoured pull: a pull counts only if fifo_push=0 in the same cycle. The FIFO gives push priority, so a pull coinciding with a push is dropped.
  - Dropped pull: FETCH returns to IDLE and the pull is reissued on the next eligible cycle.
- LOAD: osr<=fifo_data and shift_count<=0, in the cycle after an honoured pull. Pull-to-OSR latency is 2 cycles.
- Explicit PULL (pull_req=1 in IDLE):
  - FIFO not empty: fetch as above. done pulses in the LOAD cycle.
  - FIFO empty, pull_block=1: stall=1 until the FIFO is non-empty, then fetch.
  - FIFO empty, pull_block=0: osr<=scratch_x, shift_count<=0, done the same cycle.
  - With auto_pull=1 and shift_count<thresh, PULL is a no-op; done the same cycle.
- OUT (out_req=1 in IDLE), n = out_count (0 means 32):
  - auto_pull=1 and shift_count>=thresh: perform an autopull refill first. Stall while the FIFO is empty. Execute the OUT in the cycle after LOAD.
  - Otherwise execute immediately: done=1; shift_count<=min(shift_count+n, 32).
  - Right shift: out_data = osr[n-1:0]; osr<=osr>>n.
  - Left shift: out_data = osr[31:32-n]; osr<=osr<<n.
  - n=32 yields the full word and osr<=0.
- Background autopull: in IDLE with no request, auto_pull=1, shift_count>=thresh and FIFO not empty, start a refill.
- Priority: reset > LOAD completion > pull_req > out_req > background autopull.
  - pull_req and out_req together: PULL executes; OUT stalls.
- out_data holds its value until the next OUT. done is a single-cycle pulse; stall=out_req|pull_req & ~done.

Test Plan:
- Reset; push 0xDEADBEEF; PULL blocking → fifo_pull 1 cycle, osr=0xDEADBEEF and done 2 cycles later, shift_count=0.
- osr=0x12345678, shift_right=1, OUT 8 → out_data=0x78, osr=0x00123456, shift_count=8. Shift left, OUT 4 → out_data=0x1, osr=0x23456780.
- auto_pull=1, thresh=32, FIFO holds 0xA5A5A5A5 and 0x0000FFFF; OUT 32 twice → out_data 0xA5A5A5A5 then 0x0000FFFF, no stall beyond refill latency.
- Empty FIFO, PULL blocking → stall high for 5 cycles; push 0x1 → done, osr=0x1. Non-blocking PULL with scratch_x=0xCAFE → osr=0xCAFE, done immediately.
- Honoured pull coincides with fifo_push=1 → pull reissued next eligible cycle; osr receives the correct oldest word, no data skipped.
- Assert reset during FETCH → all outputs return to reset values next cycle; shift_count=32.

Source files
------------

// File: rtl/pio_osr_if.sv
// Bus between the OSR unit, the TX FIFO and the instruction execution unit.
// slave is the OSR unit's view; master is the view of whatever drives it.
interface pio_osr_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
);
    // TX FIFO side
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pull;
    logic [DATA_W-1:0] fifo_data;
    // Instruction / configuration side
    logic              auto_pull;
    logic [4:0]        pull_thresh;
    logic              shift_right;
    logic              out_req;
    logic [4:0]        out_count;
    logic              pull_req;
    logic              pull_block;
    logic [DATA_W-1:0] scratch_x;
    // Results
    logic [DATA_W-1:0] out_data;
    logic              done;
    logic              stall;
    logic [DATA_W-1:0] osr;
    logic [CNT_W-1:0]  shift_count;

    modport slave (
        input  fifo_empty, fifo_push, fifo_data,
        input  auto_pull, pull_thresh, shift_right, out_req, out_count,
        input  pull_req, pull_block, scratch_x,
        output fifo_pull, out_data, done, stall, osr, shift_count
    );

    modport master (
        output fifo_empty, fifo_push, fifo_data,
        output auto_pull, pull_thresh, shift_right, out_req, out_count,
        output pull_req, pull_block, scratch_x,
        input  fifo_pull, out_data, done, stall, osr, shift_count
    );
endinterface

// File: rtl/pio_osr_unit.sv
// PIO output shift register: refills from the TX FIFO on PULL or autopull
// and shifts 1..32 bits out per OUT instruction. done/stall answer the
// instruction in the same cycle; everything else is registered.
module pio_osr_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       reset,
    pio_osr_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] osr_q, osr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              fifo_pull_q, fifo_pull_d;
    logic              explicit_q, explicit_d;   // refill in flight belongs to a PULL
    logic              done_c;

    // Field value 0 encodes 32 for both the threshold and the OUT bit count.
    logic [CNT_W-1:0]  thresh, n;
    logic              refill_due;
    logic [DATA_W-1:0] low_mask;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_sat;

    assign thresh     = (bus.pull_thresh == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(bus.pull_thresh);
    assign n          = (bus.out_count == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(bus.out_count);
    assign refill_due = bus.auto_pull && (cnt_q >= thresh);
    assign low_mask   = ~({DATA_W{1'b1}} << n);
    assign cnt_sum    = {1'b0, cnt_q} + {1'b0, n};
    assign cnt_sat    = (cnt_sum > (CNT_W + 1)'(DATA_W)) ? CNT_W'(DATA_W) : cnt_sum[CNT_W-1:0];

    // Next-state and datapath decisions for the IDLE/FETCH/LOAD sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        osr_d       = osr_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        fifo_pull_d = 1'b0;
        explicit_d  = explicit_q;
        done_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.pull_req) begin
                    if (bus.auto_pull && (cnt_q < thresh)) begin
                        done_c = 1'b1;                 // OSR not yet drained: no-op
                    end else if (!bus.fifo_empty) begin
                        state_d     = FETCH;
                        fifo_pull_d = 1'b1;
                        explicit_d  = 1'b1;
                    end else if (!bus.pull_block) begin
                        osr_d  = bus.scratch_x;
                        cnt_d  = '0;
                        done_c = 1'b1;
                    end
                end else if (bus.out_req) begin
                    if (refill_due) begin
                        if (!bus.fifo_empty) begin
                            state_d     = FETCH;
                            fifo_pull_d = 1'b1;
                            explicit_d  = 1'b0;
                        end
                    end else begin
                        done_c = 1'b1;
                        cnt_d  = cnt_sat;
                        if (bus.shift_right) begin
                            out_data_d = osr_q & low_mask;
                            osr_d      = osr_q >> n;
                        end else begin
                            out_data_d = osr_q >> (CNT_W'(DATA_W) - n);
                            osr_d      = osr_q << n;
                        end
                    end
                end else if (refill_due && !bus.fifo_empty) begin
                    state_d     = FETCH;
                    fifo_pull_d = 1'b1;
                    explicit_d  = 1'b0;
                end
            end
            FETCH: begin
                // A push in the same cycle wins inside the FIFO; retry from IDLE.
                state_d = bus.fifo_push ? IDLE : LOAD;
            end
            LOAD: begin
                osr_d   = bus.fifo_data;
                cnt_d   = '0;
                done_c  = explicit_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset; the OSR starts empty.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; all logic lives in the _d terms.
        if (reset) begin
            state_q     <= IDLE;
            osr_q       <= '0;
            cnt_q       <= CNT_W'(DATA_W);
            out_data_q  <= '0;
            fifo_pull_q <= 1'b0;
            explicit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            osr_q       <= osr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            fifo_pull_q <= fifo_pull_d;
            explicit_q  <= explicit_d;
        end
    end

    assign bus.fifo_pull   = fifo_pull_q;
    assign bus.osr         = osr_q;
    assign bus.shift_count = cnt_q;
    assign bus.out_data    = out_data_q;
    assign bus.done        = done_c & ~reset;
    assign bus.stall       = (bus.out_req | bus.pull_req) & ~done_c & ~reset;
endmodule

// File: tb/tb_pio_osr_unit.sv
// Directed bench for pio_osr_unit with a small TX FIFO model.
module tb_pio_osr_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pio_osr_if ifc ();
    pio_osr_unit dut (.clk(clk), .reset(reset), .bus(ifc));

    // TX FIFO model: push has priority, dout valid the cycle after a pop.
    logic [31:0] fq[$];
    logic        fifo_empty_r = 1'b1;
    logic [31:0] fifo_data_r  = 32'h0;
    logic        push_r       = 1'b0;
    logic [31:0] push_data_r  = 32'h0;
    assign ifc.fifo_empty = fifo_empty_r;
    assign ifc.fifo_data  = fifo_data_r;
    assign ifc.fifo_push  = push_r;

    // FIFO storage update at the clock edge.
    always @(posedge clk) begin
        if (push_r) fq.push_back(push_data_r);
        else if (ifc.fifo_pull && fq.size() != 0) fifo_data_r <= fq.pop_front();
        fifo_empty_r <= (fq.size() == 0);
    end

    // Count cycles in which the DUT strobes fifo_pull.
    int pull_pulses = 0;
    always @(posedge clk) if (ifc.fifo_pull) pull_pulses++;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push_word(input logic [31:0] w);
        @(negedge clk);
        push_r      = 1'b1;
        push_data_r = w;
        @(negedge clk);
        push_r      = 1'b0;
    endtask

    // Called just after a negedge with a request already driven.
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        #1;
        while (ifc.done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (ifc.done !== 1'b1) begin
            n_total++;
            $display("FAIL timeout: done not seen within %0d cycles", budget);
        end
    endtask

    // Raise the request(s), wait for done, drop them the following cycle.
    task automatic issue(input bit do_pull, input bit do_out, input int budget, output int cyc);
        @(negedge clk);
        ifc.pull_req = do_pull;
        ifc.out_req  = do_out;
        wait_done(budget, cyc);
        @(negedge clk);
        ifc.pull_req = 1'b0;
        ifc.out_req  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] init;
        bit          right;
        logic [4:0]  cnt;
        logic [31:0] exp_out;
        logic [31:0] exp_osr;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cyc;
        int p0;
        int stall_cycles;

        vecs[0] = '{32'h12345678, 1'b1, 5'd8,  32'h00000078, 32'h00123456, 6'd8};
        vecs[1] = '{32'h12345678, 1'b0, 5'd4,  32'h00000001, 32'h23456780, 6'd4};
        vecs[2] = '{32'hDEADBEEF, 1'b1, 5'd0,  32'hDEADBEEF, 32'h00000000, 6'd32};
        vecs[3] = '{32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF, 32'h00000000, 6'd32};
        vecs[4] = '{32'h80000001, 1'b0, 5'd1,  32'h00000001, 32'h00000002, 6'd1};
        vecs[5] = '{32'h80000001, 1'b1, 5'd1,  32'h00000001, 32'h40000000, 6'd1};
        vecs[6] = '{32'hF0F0F0F0, 1'b1, 5'd31, 32'h70F0F0F0, 32'h00000001, 6'd31};
        vecs[7] = '{32'hF0F0F0F0, 1'b0, 5'd31, 32'h78787878, 32'h00000000, 6'd31};
        vecs[8] = '{32'hCAFEBABE, 1'b0, 5'd16, 32'h0000CAFE, 32'hBABE0000, 6'd16};
        vecs[9] = '{32'hCAFEBABE, 1'b1, 5'd12, 32'h00000ABE, 32'h000CAFEB, 6'd12};

        ifc.auto_pull   = 1'b0;
        ifc.pull_thresh = 5'd0;
        ifc.shift_right = 1'b1;
        ifc.out_req     = 1'b0;
        ifc.out_count   = 5'd0;
        ifc.pull_req    = 1'b0;
        ifc.pull_block  = 1'b1;
        ifc.scratch_x   = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst osr", ifc.osr, 32'h0);
        check("rst shift_count", ifc.shift_count, 32'd32);
        check("rst out_data", ifc.out_data, 32'h0);
        check("rst done", ifc.done, 32'h0);
        check("rst stall", ifc.stall, 32'h0);
        check("rst fifo_pull", ifc.fifo_pull, 32'h0);

        // Blocking PULL with a word available
        push_word(32'hDEADBEEF);
        p0 = pull_pulses;
        issue(1'b1, 1'b0, 10, cyc);
        check("pull latency", cyc, 32'd2);
        check("pull pulses", pull_pulses - p0, 32'd1);
        check("pull osr", ifc.osr, 32'hDEADBEEF);
        check("pull shift_count", ifc.shift_count, 32'd0);

        // Shift vectors: preload through a non-blocking PULL on the empty FIFO
        ifc.pull_block = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ifc.scratch_x = vecs[i].init;
            issue(1'b1, 1'b0, 4, cyc);
            ifc.shift_right = vecs[i].right;
            ifc.out_count   = vecs[i].cnt;
            issue(1'b0, 1'b1, 4, cyc);
            check($sformatf("vec%0d out_data", i), ifc.out_data, vecs[i].exp_out);
            check($sformatf("vec%0d osr", i), ifc.osr, vecs[i].exp_osr);
            check($sformatf("vec%0d shift_count", i), ifc.shift_count, vecs[i].exp_cnt);
        end

        // shift_count saturates at 32
        ifc.scratch_x = 32'h12345678;
        issue(1'b1, 1'b0, 4, cyc);
        ifc.shift_right = 1'b1;
        ifc.out_count   = 5'd20;
        issue(1'b0, 1'b1, 4, cyc);
        check("sat1 out_data", ifc.out_data, 32'h00045678);
        check("sat1 osr", ifc.osr, 32'h00000123);
        check("sat1 shift_count", ifc.shift_count, 32'd20);
        issue(1'b0, 1'b1, 4, cyc);
        check("sat2 out_data", ifc.out_data, 32'h00000123);
        check("sat2 osr", ifc.osr, 32'h0);
        check("sat2 shift_count", ifc.shift_count, 32'd32);

        // PULL and OUT together: PULL wins, OUT does not shift
        ifc.scratch_x = 32'h0BADF00D;
        issue(1'b1, 1'b1, 4, cyc);
        check("both latency", cyc, 32'd0);
        check("both osr", ifc.osr, 32'h0BADF00D);
        check("both shift_count", ifc.shift_count, 32'd0);
        check("both out_data kept", ifc.out_data, 32'h00000123);

        // Autopull enabled and OSR above threshold: PULL is a no-op
        ifc.auto_pull   = 1'b1;
        ifc.pull_thresh = 5'd16;
        ifc.scratch_x   = 32'h55555555;
        issue(1'b1, 1'b0, 4, cyc);
        check("noop latency", cyc, 32'd0);
        check("noop osr", ifc.osr, 32'h0BADF00D);
        ifc.auto_pull = 1'b0;

        // Blocking PULL on empty FIFO stalls until a word arrives
        ifc.pull_block = 1'b1;
        @(negedge clk);
        ifc.pull_req = 1'b1;
        stall_cycles = 0;
        repeat (5) begin
            #1;
            if (ifc.stall === 1'b1 && ifc.done === 1'b0) stall_cycles++;
            @(negedge clk);
        end
        check("block stall cycles", stall_cycles, 32'd5);
        push_r      = 1'b1;
        push_data_r = 32'h00000001;
        @(negedge clk);
        push_r = 1'b0;
        wait_done(10, cyc);
        @(negedge clk);
        ifc.pull_req = 1'b0;
        check("block osr", ifc.osr, 32'h00000001);
        check("block shift_count", ifc.shift_count, 32'd0);

        // Non-blocking PULL on empty FIFO takes X
        ifc.pull_block = 1'b0;
        ifc.scratch_x  = 32'h0000CAFE;
        issue(1'b1, 1'b0, 4, cyc);
        check("nb latency", cyc, 32'd0);
        check("nb osr", ifc.osr, 32'h0000CAFE);

        // Pull coinciding with a push is dropped and reissued
        ifc.pull_block = 1'b1;
        push_word(32'h11111111);
        p0 = pull_pulses;
        @(negedge clk);
        ifc.pull_req = 1'b1;
        @(negedge clk);
        #1;
        check("drop fifo_pull in fetch", ifc.fifo_pull, 32'h1);
        push_r      = 1'b1;
        push_data_r = 32'h22222222;
        @(negedge clk);
        push_r = 1'b0;
        wait_done(10, cyc);
        @(negedge clk);
        ifc.pull_req = 1'b0;
        check("drop retry latency", cyc, 32'd2);
        check("drop pull pulses", pull_pulses - p0, 32'd2);
        check("drop osr oldest", ifc.osr, 32'h11111111);
        issue(1'b1, 1'b0, 10, cyc);
        check("drop second osr", ifc.osr, 32'h22222222);

        // Reset during FETCH
        push_word(32'h33333333);
        @(negedge clk);
        ifc.pull_req = 1'b1;
        @(negedge clk);
        #1;
        check("rf fifo_pull in fetch", ifc.fifo_pull, 32'h1);
        reset        = 1'b1;
        ifc.pull_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rf osr", ifc.osr, 32'h0);
        check("rf shift_count", ifc.shift_count, 32'd32);
        check("rf out_data", ifc.out_data, 32'h0);
        check("rf done", ifc.done, 32'h0);
        check("rf stall", ifc.stall, 32'h0);
        check("rf fifo_pull", ifc.fifo_pull, 32'h0);

        // Autopull at threshold 32, two full-word OUTs
        ifc.auto_pull   = 1'b1;
        ifc.pull_thresh = 5'd0;
        ifc.shift_right = 1'b1;
        ifc.out_count   = 5'd0;
        push_word(32'hA5A5A5A5);
        push_word(32'h0000FFFF);
        issue(1'b0, 1'b1, 10, cyc);
        check("ap1 latency bound", (cyc <= 3) ? 32'h1 : 32'h0, 32'h1);
        check("ap1 out_data", ifc.out_data, 32'hA5A5A5A5);
        issue(1'b0, 1'b1, 10, cyc);
        check("ap2 latency bound", (cyc <= 3) ? 32'h1 : 32'h0, 32'h1);
        check("ap2 out_data", ifc.out_data, 32'h0000FFFF);
        check("ap2 osr", ifc.osr, 32'h0);
        check("ap2 shift_count", ifc.shift_count, 32'd32);
        ifc.auto_pull = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
